uart_regs_responder: RTL

//  16550-style UART responder: the register slave answering the host-side FSM's

---
 rtl/uart_regs_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_regs_responder.sv
// ---------------------------------------------------------------------------
// uart_regs_responder
//   16550-style UART register slave. Holds the DLL/DLM/IER/IIR-FCR/LCR/LSR
//   register map, a TX FIFO feeding an 8N1 serializer and a 16x-oversampling
//   RX deserializer feeding an RX FIFO.
//
// Ports
//   CLK           in   system clock, rising edge
//   RESET         in   synchronous, active-high reset
//   uart_addr_i   in   [2:0] register address
//   uart_wdata_i  in   [7:0] write data
//   uart_we_i     in   write strobe, one write per cycle high
//   uart_re_i     in   read strobe, one read per cycle high
//   uart_rdata_o  out  [7:0] read data, valid the cycle after re
//   uart_tx_o     out  serial out, idle high
//   uart_rx_i     in   serial in, asynchronous
//   uart_irq_o    out  interrupt, active high
//
// Optional feature: define UART_LOOPBACK_EN to get MCR at address 4 with
// MCR[4] looping the TX stream into the RX synchronizer.
// ---------------------------------------------------------------------------
module uart_regs_responder #(
    parameter int unsigned FIFO_AW  = 4,
    parameter logic [15:0] DL_RESET = 16'h000E
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] uart_addr_i,
    input  logic [7:0] uart_wdata_i,
    input  logic       uart_we_i,
    input  logic       uart_re_i,
    output logic [7:0] uart_rdata_o,
    output logic       uart_tx_o,
    input  logic       uart_rx_i,
    output logic       uart_irq_o
);
    localparam int unsigned       DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- register file / access decode ----------------
    logic [7:0] dll, dlm, lcr;
    logic [1:0] ier;
    logic       fcr0;
    logic       oe, fe;
    logic       dlab;
    logic       wr_thr, wr_dll, wr_ier, wr_dlm, wr_fcr, wr_lcr;
    logic       rd_rbr, rd_lsr;
    logic       flush_rx, flush_tx;

    assign dlab     = lcr[7];
    assign wr_thr   = uart_we_i && uart_addr_i == 3'd0 && !dlab;
    assign wr_dll   = uart_we_i && uart_addr_i == 3'd0 &&  dlab;
    assign wr_ier   = uart_we_i && uart_addr_i == 3'd1 && !dlab;
    assign wr_dlm   = uart_we_i && uart_addr_i == 3'd1 &&  dlab;
    assign wr_fcr   = uart_we_i && uart_addr_i == 3'd2;
    assign wr_lcr   = uart_we_i && uart_addr_i == 3'd3;
    assign rd_rbr   = uart_re_i && uart_addr_i == 3'd0 && !dlab;
    assign rd_lsr   = uart_re_i && uart_addr_i == 3'd5;
    assign flush_rx = wr_fcr && uart_wdata_i[1];
    assign flush_tx = wr_fcr && uart_wdata_i[2];

`ifdef UART_LOOPBACK_EN
    logic mcr_loop;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dll  <= DL_RESET[7:0];
            dlm  <= DL_RESET[15:8];
            lcr  <= '0;
            ier  <= '0;
            fcr0 <= 1'b0;
`ifdef UART_LOOPBACK_EN
            mcr_loop <= 1'b0;
`endif
        end else begin
            if (wr_dll) dll  <= uart_wdata_i;
            if (wr_dlm) dlm  <= uart_wdata_i;
            if (wr_lcr) lcr  <= uart_wdata_i;
            if (wr_ier) ier  <= uart_wdata_i[1:0];
            if (wr_fcr) fcr0 <= uart_wdata_i[0];
`ifdef UART_LOOPBACK_EN
            if (uart_we_i && uart_addr_i == 3'd4) mcr_loop <= uart_wdata_i[4];
`endif
        end
    end

    // ---------------- baud generator ----------------
    logic [15:0] dl, dl_eff, baud_cnt;
    logic        tick;

    assign dl     = {dlm, dll};
    assign dl_eff = (dl == 16'd0) ? 16'd1 : dl;
    assign tick   = (baud_cnt == dl_eff - 16'd1);

    always_ff @(posedge CLK) begin
        if (RESET || wr_dll || wr_dlm) baud_cnt <= '0;
        else if (tick)                 baud_cnt <= '0;
        else                           baud_cnt <= baud_cnt + 16'd1;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [FIFO_AW:0]   tx_cnt;
    logic               tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_push  = wr_thr && !tx_full;

    always_ff @(posedge CLK) begin
        if (tx_push && !flush_tx) tx_mem[tx_wp] <= uart_wdata_i;
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush_tx) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
        end
    end

    // ---------------- TX serializer ----------------
    tx_state_t  tx_state, tx_next;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;
    logic [3:0] tx_tick;
    logic       tx_bit_end, tx_serial;

    assign tx_bit_end = tick && (tx_tick == 4'd15);

    always_ff @(posedge CLK) begin
        if (RESET) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // The pop is issued from STOP as well as IDLE so consecutive frames abut.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_next = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_serial = 1'b1;
        case (tx_state)
            TX_START: tx_serial = 1'b0;
            TX_DATA:  tx_serial = tx_shift[0];
            default:  tx_serial = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_tick  <= '0;
        end else if (tx_pop) begin
            tx_shift <= tx_mem[tx_rp];
            tx_bit   <= '0;
            tx_tick  <= '0;
        end else if (tick) begin
            tx_tick <= tx_tick + 4'd1;
            if (tx_state == TX_DATA && tx_tick == 4'd15) begin
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX synchronizer ----------------
    logic rx_in, rx_s1, rx_s2, rx_prev, rx_fall;

`ifdef UART_LOOPBACK_EN
    assign rx_in     = mcr_loop ? tx_serial : uart_rx_i;
    assign uart_tx_o = mcr_loop ? 1'b1 : tx_serial;
`else
    assign rx_in     = uart_rx_i;
    assign uart_tx_o = tx_serial;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    // ---------------- RX deserializer ----------------
    rx_state_t  rx_state, rx_next;
    logic [7:0] rx_shift;
    logic [2:0] rx_bit;
    logic [3:0] rx_tick;
    logic       rx_bit_end, rx_done;

    assign rx_bit_end = tick && (rx_tick == 4'd15);

    always_ff @(posedge CLK) begin
        if (RESET) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (tick && rx_tick == 4'd7) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done = (rx_state == RX_STOP) && rx_bit_end;
    end

    // The tick count restarts after the start-bit check so that every
    // following sample lands 16 ticks later, i.e. mid-bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_tick  <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_bit  <= '0;
            rx_tick <= '0;
        end else if (tick) begin
            if (rx_state == RX_START && rx_tick == 4'd7) rx_tick <= '0;
            else                                        rx_tick <= rx_tick + 4'd1;
            if (rx_state == RX_DATA && rx_tick == 4'd15) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [FIFO_AW:0]   rx_cnt;
    logic               rx_empty, rx_full, rx_push, rx_pop, rx_ovf;
    logic [7:0]         rx_last;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_pop   = rd_rbr && !rx_empty;
    assign rx_push  = rx_done && (!rx_full || rx_pop);
    assign rx_ovf   = rx_done && rx_full && !rx_pop;

    always_ff @(posedge CLK) begin
        if (rx_push && !flush_rx) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush_rx) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)       rx_last <= '0;
        else if (rx_pop) rx_last <= rx_mem[rx_rp];
    end

    // Error flags: a new event in the same cycle as an LSR read is kept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            oe <= 1'b0;
            fe <= 1'b0;
        end else begin
            if (rd_lsr)             oe <= 1'b0;
            if (rx_ovf)             oe <= 1'b1;
            if (rd_lsr)             fe <= 1'b0;
            if (rx_done && !rx_s2)  fe <= 1'b1;
        end
    end

    // ---------------- status, read mux, interrupt ----------------
    logic       dr, thre, temt;
    logic [7:0] lsr, iir, rd_val;

    assign dr   = !rx_empty;
    assign thre = tx_empty;
    assign temt = tx_empty && (tx_state == TX_IDLE);
    assign lsr  = {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};

    always_comb begin
        if (ier[0] && dr)        iir = 8'h04;
        else if (ier[1] && thre) iir = 8'h02;
        else                     iir = 8'h01;
        if (fcr0) iir = iir | 8'hC0;
    end

    always_comb begin
        rd_val = '0;
        case (uart_addr_i)
            3'd0: rd_val = dlab ? dll : (rx_empty ? rx_last : rx_mem[rx_rp]);
            3'd1: rd_val = dlab ? dlm : {6'b0, ier};
            3'd2: rd_val = iir;
            3'd3: rd_val = lcr;
`ifdef UART_LOOPBACK_EN
            3'd4: rd_val = {3'b0, mcr_loop, 4'b0};
`endif
            3'd5: rd_val = lsr;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            uart_rdata_o <= '0;
            uart_irq_o   <= 1'b0;
        end else begin
            if (uart_re_i) uart_rdata_o <= rd_val;
            uart_irq_o <= (ier[0] && dr) || (ier[1] && thre);
        end
    end

endmodule
